mem_access_unit: RTL and testbench

- Data-memory access stage directly downstream of the load/store size decoder.
- Consumes MemWrite/SizeLoad encodings plus the effective address and store data.
- Drives a 32-bit word-addressed memory bus with byte enables and returns sign/zero-extended load data.
- Splits misaligned accesses that cross a word boundary into two bus beats, stalling the pipeline while busy.

---
 rtl/mem_size_pkg.sv | 18 +
 rtl/load_align_ext.sv | 14 +
 rtl/mem_access_unit.sv | 101 ++++++++++
 tb/tb_mem_access_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mem_size_pkg.sv
// mem_size_pkg: load/store size encodings, access-state enum and size decode
package mem_size_pkg;
  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_WORD = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_BYTE = 2'b11;
  localparam logic [2:0] SL_LW  = 3'b000;
  localparam logic [2:0] SL_LH  = 3'b001;
  localparam logic [2:0] SL_LB  = 3'b010;
  localparam logic [2:0] SL_LBU = 3'b011;
  localparam logic [2:0] SL_LHU = 3'b100;
  typedef enum logic [1:0] {IDLE, B0, B1, DONE} state_t;
  // access width in bytes; reserved load sizes fall back to a full word
  function automatic logic [2:0] size_bytes(input logic st, input logic [1:0] mw, input logic [2:0] sl);
    return st ? (mw == MW_HALF ? 3'd2 : mw == MW_BYTE ? 3'd1 : 3'd4) :
           (sl == SL_LH || sl == SL_LHU) ? 3'd2 : (sl == SL_LB || sl == SL_LBU) ? 3'd1 : 3'd4;
  endfunction
endpackage

// File: rtl/load_align_ext.sv
// load_align_ext: extract the addressed bytes from a two-word window and extend them
module load_align_ext import mem_size_pkg::*; (
  input  logic [63:0] data,
  input  logic [1:0]  o,
  input  logic [2:0]  sl,
  output logic [31:0] ld
);
  logic [31:0] w;
  assign w = 32'(data >> {o, 3'b000});
  assign ld = sl == SL_LH  ? {{16{w[15]}}, w[15:0]} :
              sl == SL_LB  ? {{24{w[7]}}, w[7:0]} :
              sl == SL_LBU ? {24'b0, w[7:0]} :
              sl == SL_LHU ? {16'b0, w[15:0]} : w;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store bus stage that splits word-crossing accesses into two beats
module mem_access_unit import mem_size_pkg::*; #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        LoadOp,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  SizeLoad,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] LoadData,
  output logic        Done,
  output logic        MisalignErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  state_t state;
  logic st, req, we_q;
  logic [2:0] n, sl_q;
  logic [3:0] bm;
  logic [7:0] m_in, m_q;
  logic [1:0] o_q;
  logic [31:0] base_q, wd_q, r0, ext;
  logic [63:0] wsh;
  assign st = MemWrite != MW_NONE;
  assign req = st | LoadOp;
  assign n = size_bytes(st, MemWrite, SizeLoad);
  assign bm = n == 3'd4 ? 4'hF : n == 3'd2 ? 4'h3 : 4'h1;
  assign m_in = {4'b0, bm} << Addr[1:0];
  assign wsh = {32'b0, wd_q} << {o_q, 3'b000};
  assign mem_req = state == B0 || state == B1;
  assign mem_we = mem_req & we_q;
  assign mem_addr = state == B0 ? base_q : state == B1 ? base_q + 32'd4 : '0;
  assign mem_be = state == B0 ? m_q[3:0] : state == B1 ? m_q[7:4] : '0;
  assign mem_wdata = state == B0 ? wsh[31:0] : state == B1 ? wsh[63:32] : '0;
  assign Stall = mem_req | (state == IDLE && req);
  // the word arriving this cycle is spliced in so LoadData can be registered on the final beat
  load_align_ext u_ext (
    .data({state == B1 ? mem_rdata : 32'b0, state == B0 ? mem_rdata : r0}),
    .o(o_q),
    .sl(sl_q),
    .ld(ext)
  );
  // access sequencer: latch request, run one or two bus beats, pulse completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      Done <= 1'b0;
      MisalignErr <= 1'b0;
      LoadData <= '0;
      we_q <= 1'b0;
      sl_q <= '0;
      o_q <= '0;
      m_q <= '0;
      base_q <= '0;
      wd_q <= '0;
      r0 <= '0;
    end else begin
      Done <= 1'b0;
      MisalignErr <= 1'b0;
      LoadData <= '0;
      case (state)
        IDLE: if (req) begin
          we_q <= st;
          sl_q <= SizeLoad > SL_LHU ? SL_LW : SizeLoad;
          o_q <= Addr[1:0];
          m_q <= m_in;
          base_q <= {Addr[31:2], 2'b00};
          wd_q <= WriteData;
          if (!SPLIT_MISALIGNED && m_in[7:4] != 4'b0) begin
            state <= DONE;
            Done <= 1'b1;
            MisalignErr <= 1'b1;
          end else state <= B0;
        end
        B0: if (mem_ready) begin
          r0 <= mem_rdata;
          if (m_q[7:4] != 4'b0) state <= B1;
          else begin
            state <= DONE;
            Done <= 1'b1;
            LoadData <= we_q ? '0 : ext;
          end
        end
        B1: if (mem_ready) begin
          state <= DONE;
          Done <= 1'b1;
          LoadData <= we_q ? '0 : ext;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vectors against hand-computed bus beats and load results
module tb_mem_access_unit;
  import mem_size_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, LoadOp = 1'b0, mem_ready = 1'b0, sel = 1'b0;
  logic [1:0] MemWrite = '0;
  logic [2:0] SizeLoad = '0;
  logic [31:0] Addr = '0, WriteData = '0, mem_rdata = '0;
  logic stall1, done1, err1, req1, we1, stall0, done0, err0, req0, we0;
  logic [31:0] ld1, addr1, wdata1, ld0, addr0, wdata0;
  logic [3:0] be1, be0;
  logic o_stall, o_done, o_err, o_req, o_we;
  logic [31:0] o_ld, o_addr, o_wdata;
  logic [3:0] o_be;
  int n_chk = 0, n_fail = 0;
  int nb, ns, ncyc;
  logic [31:0] b_addr[2], b_wd[2], ld_res;
  logic [3:0] b_be[2];
  logic b_we[2];
  logic err_res, unstable, req_seen, got_done;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .LoadOp(LoadOp), .MemWrite(MemWrite), .SizeLoad(SizeLoad),
    .Addr(Addr), .WriteData(WriteData), .Stall(stall1), .LoadData(ld1), .Done(done1),
    .MisalignErr(err1), .mem_req(req1), .mem_we(we1), .mem_addr(addr1), .mem_be(be1),
    .mem_wdata(wdata1), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );
  mem_access_unit #(.SPLIT_MISALIGNED(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .LoadOp(LoadOp), .MemWrite(MemWrite), .SizeLoad(SizeLoad),
    .Addr(Addr), .WriteData(WriteData), .Stall(stall0), .LoadData(ld0), .Done(done0),
    .MisalignErr(err0), .mem_req(req0), .mem_we(we0), .mem_addr(addr0), .mem_be(be0),
    .mem_wdata(wdata0), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  assign o_stall = sel ? stall0 : stall1;
  assign o_done = sel ? done0 : done1;
  assign o_err = sel ? err0 : err1;
  assign o_req = sel ? req0 : req1;
  assign o_we = sel ? we0 : we1;
  assign o_ld = sel ? ld0 : ld1;
  assign o_addr = sel ? addr0 : addr1;
  assign o_wdata = sel ? wdata0 : wdata1;
  assign o_be = sel ? be0 : be1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    LoadOp = 1'b0;
    MemWrite = MW_NONE;
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic op(input logic lo, input logic [1:0] mw, input logic [2:0] sl, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] r0v, input logic [31:0] r1v, input int waits);
    int wc = 0;
    nb = 0; ns = 0; ncyc = 0; unstable = 0; req_seen = 0; got_done = 0; ld_res = '0; err_res = 0;
    @(negedge clk);
    LoadOp = lo; MemWrite = mw; SizeLoad = sl; Addr = a; WriteData = wd;
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      mem_rdata = nb == 0 ? r0v : r1v;
      mem_ready = o_req && (nb > 0 || wc >= waits);
      #1;
      ncyc = c + 1;
      if (o_stall) ns++;
      if (o_req) req_seen = 1;
      if (o_done) begin
        got_done = 1; ld_res = o_ld; err_res = o_err;
        LoadOp = 1'b0; MemWrite = MW_NONE; mem_ready = 1'b0;
      end else if (o_req && nb < 2) begin
        if (wc == 0) begin
          b_addr[nb] = o_addr; b_be[nb] = o_be; b_wd[nb] = o_wdata; b_we[nb] = o_we;
        end else if ({o_addr, o_be, o_wdata, o_we} !== {b_addr[nb], b_be[nb], b_wd[nb], b_we[nb]}) unstable = 1;
        if (mem_ready) begin nb++; wc = 0; end else wc++;
      end
    end
    check("done_seen", got_done, 1);
    @(negedge clk);
    #1;
    check("done_pulse", o_done, 0);
    check("idle_stall", o_stall, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", stall1, 0);
    check("rst_done", done1, 0);
    check("rst_req", req1, 0);
    check("rst_addr", addr1, 0);
    check("rst_ld", ld1, 0);
    rst_n = 1'b1;

    op(1, MW_NONE, SL_LW, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    check("lw_beats", nb, 1); check("lw_addr", b_addr[0], 32'h100); check("lw_be", b_be[0], 4'hF);
    check("lw_we", b_we[0], 0); check("lw_data", ld_res, 32'hDEADBEEF);
    check("lw_stall", ns, 2); check("lw_cycles", ncyc, 3);

    op(0, MW_BYTE, SL_LW, 32'h203, 32'hA5, 0, 0, 0);
    check("sb_beats", nb, 1); check("sb_addr", b_addr[0], 32'h200); check("sb_be", b_be[0], 4'h8);
    check("sb_wdata", b_wd[0], 32'hA500_0000); check("sb_we", b_we[0], 1); check("sb_ld", ld_res, 0);

    op(1, MW_NONE, SL_LH, 32'h0FF, 0, 32'h8012_3456, 32'h1234_56FF, 0);
    check("lh_beats", nb, 2); check("lh_addr0", b_addr[0], 32'h0FC); check("lh_be0", b_be[0], 4'h8);
    check("lh_addr1", b_addr[1], 32'h100); check("lh_be1", b_be[1], 4'h1);
    check("lh_data", ld_res, 32'hFFFF_FF80); check("lh_stall", ns, 3); check("lh_cycles", ncyc, 4);

    op(1, MW_NONE, SL_LHU, 32'h0FF, 0, 32'h8012_3456, 32'h1234_56FF, 0);
    check("lhu_data", ld_res, 32'h0000_FF80);

    op(0, MW_WORD, SL_LW, 32'hFFFF_FFFE, 32'h1122_3344, 0, 0, 0);
    check("sw_beats", nb, 2); check("sw_addr0", b_addr[0], 32'hFFFF_FFFC); check("sw_be0", b_be[0], 4'hC);
    check("sw_wd0", b_wd[0], 32'h3344_0000); check("sw_addr1", b_addr[1], 32'h0); check("sw_be1", b_be[1], 4'h3);
    check("sw_wd1", b_wd[1], 32'h0000_1122); check("sw_we1", b_we[1], 1);

    op(1, MW_NONE, SL_LW, 32'h100, 0, 32'hDEADBEEF, 0, 3);
    check("wait_stable", unstable, 0); check("wait_stall", ns, 5); check("wait_cycles", ncyc, 6);
    check("wait_data", ld_res, 32'hDEADBEEF);

    op(1, MW_NONE, SL_LB, 32'h102, 0, 32'h00C3_0000, 0, 0);
    check("lb_data", ld_res, 32'hFFFF_FFC3);
    op(1, MW_NONE, SL_LBU, 32'h102, 0, 32'h00C3_0000, 0, 0);
    check("lbu_data", ld_res, 32'h0000_00C3);

    op(1, MW_HALF, SL_LB, 32'h302, 32'hABCD, 32'hFFFF_FFFF, 0, 0);
    check("sh_be", b_be[0], 4'hC); check("sh_wdata", b_wd[0], 32'hABCD_0000);
    check("sh_we", b_we[0], 1); check("sh_ld", ld_res, 0);

    op(1, MW_NONE, 3'b111, 32'h104, 0, 32'h89AB_CDEF, 0, 0);
    check("slrsv_addr", b_addr[0], 32'h104); check("slrsv_be", b_be[0], 4'hF);
    check("slrsv_data", ld_res, 32'h89AB_CDEF);

    @(negedge clk);
    LoadOp = 1'b1; SizeLoad = SL_LH; Addr = 32'h0FF; mem_rdata = 32'h8012_3456; mem_ready = 1'b1;
    @(negedge clk);
    #1;
    check("rst_b0_req", o_req, 1);
    @(negedge clk);
    #1;
    check("rst_b1_addr", o_addr, 32'h100);
    mem_ready = 1'b0; rst_n = 1'b0; LoadOp = 1'b0;
    @(negedge clk);
    #1;
    check("rstb1_req", o_req, 0); check("rstb1_stall", o_stall, 0); check("rstb1_done", o_done, 0);
    check("rstb1_be", o_be, 0); check("rstb1_addr", o_addr, 0); check("rstb1_wdata", o_wdata, 0);
    check("rstb1_ld", o_ld, 0); check("rstb1_err", o_err, 0);
    rst_n = 1'b1;

    sel = 1'b1;
    do_reset();
    op(1, MW_NONE, SL_LW, 32'h102, 0, 32'h1111_1111, 0, 0);
    check("nosplit_req", req_seen, 0); check("nosplit_err", err_res, 1);
    check("nosplit_ld", ld_res, 0); check("nosplit_cycles", ncyc, 2);
    do_reset();
    op(1, MW_NONE, SL_LB, 32'h102, 0, 32'h00C3_0000, 0, 0);
    check("nosplit_lb_err", err_res, 0); check("nosplit_lb_data", ld_res, 32'hFFFF_FFC3);
    check("nosplit_lb_beats", nb, 1); check("nosplit_lb_be", b_be[0], 4'h4);
    check("nosplit_lb_addr", b_addr[0], 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
